// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified memory port arbiter.
//   owner_t            : which port won the most recent grant
//                        (OWN_IDLE after reset, before any grant)
//   DEFAULT_MAX_GRANTS : default number of back-to-back contended core grants
//                        before port D is given a slot (fairness build only)
// ---------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_IDLE,
      OWN_C,
      OWN_D
   } owner_t;

   localparam int DEFAULT_MAX_GRANTS = 4;

endpackage

// File: rtl/arb_fair_cnt.sv
// ---------------------------------------------------------------------------
// arb_fair_cnt
// Saturating contention counter for the fairness build of mem_port_arbiter.
// Counts core grants made while port D is waiting. Once MAX_GRANTS such
// grants have happened in a row, force_d asks the arbiter to hand the next
// contended slot to port D.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   c_gnt    in   core was granted this cycle
//   d_req    in   port D is requesting this cycle
//   d_gnt    in   port D was granted this cycle
//   force_d  out  port D must win the current contended cycle
// ---------------------------------------------------------------------------
module arb_fair_cnt
   import mem_arb_pkg::*;
#(
   parameter int MAX_GRANTS = DEFAULT_MAX_GRANTS
) (
   input  logic clk,
   input  logic rst,
   input  logic c_gnt,
   input  logic d_req,
   input  logic d_gnt,
   output logic force_d
);

   localparam int CNT_W = $clog2(MAX_GRANTS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_GRANTS);

   logic [CNT_W-1:0] count;

   // The count only means something while D is actually waiting, so it is
   // cleared whenever D drops its request or finally gets served. It stops
   // at CNT_MAX rather than wrapping, so a stalled D can never lose its turn.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (!d_req || d_gnt) begin
         count <= '0;
      end else if (c_gnt && (count != CNT_MAX)) begin
         count <= count + 1'b1;
      end
   end

   assign force_d = d_req && (count == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single unified instruction/data memory between the multi-cycle
// core (port C) and the program loader / DMA (port D). One access per cycle.
// Read data is registered and returned with a one-cycle rvalid pulse to the
// port that issued the read.
//
// Build option:
//   MEM_ARB_FAIRNESS_EN  when defined, port D is forced a slot after
//                        MAX_GRANTS consecutive contended core grants
//                        (uses arb_fair_cnt). When undefined the arbiter is
//                        pure fixed priority (core always wins) and D may
//                        starve.
//
// Ports:
//   clk, rst               clock (rising edge), synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata  core request, held stable until c_gnt
//   c_gnt                  core access performed this cycle
//   c_rvalid               core read data valid (cycle after a read grant)
//   d_req/d_we/d_addr/d_wdata/d_gnt/d_rvalid  same for port D
//   rdata                  registered read data, shared by both ports
//   mem_addr/mem_wdata/mem_we  to memory (write on rising clk edge)
//   mem_rdata              from memory, combinational read
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
`ifdef MEM_ARB_FAIRNESS_EN
   ,
   parameter int MAX_GRANTS = DEFAULT_MAX_GRANTS
`endif
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic              c_rvalid,

   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,

   output logic [DATA_W-1:0] rdata,

   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   owner_t owner;
   logic   rd_pend;
   logic   rd_next;

`ifdef MEM_ARB_FAIRNESS_EN
   logic force_d;

   // Tracks how long D has been waiting behind the core.
   arb_fair_cnt #(
      .MAX_GRANTS (MAX_GRANTS)
   ) u_fair_cnt (
      .clk     (clk),
      .rst     (rst),
      .c_gnt   (c_gnt),
      .d_req   (d_req),
      .d_gnt   (d_gnt),
      .force_d (force_d)
   );
`endif

   // Grant decision. Grants are combinational so an access completes in the
   // same cycle it is requested; nothing is granted while reset is held so a
   // requester that stays asserted through reset cannot write memory.
   // Normally the core wins any contended cycle; in the fairness build a
   // long-waiting D takes the slot instead.
   always_comb begin
      c_gnt = 1'b0;
      d_gnt = 1'b0;
      if (!rst) begin
`ifdef MEM_ARB_FAIRNESS_EN
         if (d_req && (!c_req || force_d)) begin
            d_gnt = 1'b1;
         end else if (c_req) begin
            c_gnt = 1'b1;
         end
`else
         if (c_req) begin
            c_gnt = 1'b1;
         end else if (d_req) begin
            d_gnt = 1'b1;
         end
`endif
      end
   end

   // Memory-side mux. The core's address/data are presented whenever D is
   // not the winner, which keeps the idle bus pointing at the core. The
   // write strobe only fires for a granted write.
   always_comb begin
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
      mem_we    = c_gnt & c_we;
      if (d_gnt) begin
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
         mem_we    = d_we;
      end
   end

   assign rd_next = (c_gnt && !c_we) || (d_gnt && !d_we);

   // Owner state, read-return flag and read data register. Owner records the
   // last winner and holds through idle cycles; combined with rd_pend it
   // steers the single rvalid pulse back to whichever port issued the read.
   // rdata only loads on a read grant so it holds its value otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner   <= OWN_IDLE;
         rd_pend <= 1'b0;
         rdata   <= '0;
      end else begin
         rd_pend <= rd_next;
         if (c_gnt) begin
            owner <= OWN_C;
         end else if (d_gnt) begin
            owner <= OWN_D;
         end
         if (rd_next) begin
            rdata <= mem_rdata;
         end
      end
   end

   // A reset arriving while a read is in flight kills the pulse immediately,
   // so the requester never sees data from an access it must reissue.
   assign c_rvalid = rd_pend && (owner == OWN_C) && !rst;
   assign d_rvalid = rd_pend && (owner == OWN_D) && !rst;

endmodule
